// File: rtl/sram_port_sequencer_if.sv
// Request/response bundle between the two requesting ports (A: data, B: fetch)
// and the SRAM port sequencer.
interface sram_port_sequencer_if;
    // Handshake: a port raises req with its command fields stable and holds
    // them until its one-cycle ready pulse; req is dropped in the ready cycle.
    logic        aReq;
    logic        aWe;
    logic [15:0] aAddr;
    logic [15:0] aWdata;
    logic [15:0] aRdata;
    logic        aReady;
    logic        bReq;
    logic [15:0] bAddr;
    logic [15:0] bRdata;
    logic        bReady;

    modport master (
        output aReq, aWe, aAddr, aWdata, bReq, bAddr,
        input  aRdata, aReady, bRdata, bReady
    );

    modport slave (
        input  aReq, aWe, aAddr, aWdata, bReq, bAddr,
        output aRdata, aReady, bRdata, bReady
    );
endinterface

// File: rtl/sram_port_sequencer.sv
// Arbitrates port A (read/write) and port B (read-only) onto one asynchronous
// 16-bit SRAM with fixed SETUP / ACCESS / DONE phases and per-port ready pulses.
module sram_port_sequencer #(
    parameter int         ACCESS_CYCLES = 2,
    parameter logic [1:0] ADDR_HI       = 2'b00
) (
    input  logic                        clk,
    input  logic                        rst,
    sram_port_sequencer_if.slave        ports,
    inout  wire  [15:0]                 memDataBus,
    output logic [17:0]                 memAddrBus,
    output logic                        memRead,
    output logic                        memWrite,
    output logic                        memEnable,
    output logic [1:0]                  dbg_state,
    output logic                        dbg_drive
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        grant_b;
    logic        last_b;
    logic        we_r;
    logic        drive_en;
    logic [15:0] wdata_r;

    logic a_cand;
    logic b_cand;
    logic grant_any;
    logic pick_b;

    // In DONE the served port's req is still high from before its ready pulse,
    // so it is stale and must not win a second grant.
    always_comb begin
        a_cand    = ports.aReq && !(state == DONE && !grant_b);
        b_cand    = ports.bReq && !(state == DONE && grant_b);
        grant_any = a_cand || b_cand;
        pick_b    = b_cand && (!a_cand || !last_b);
    end

    assign memDataBus = drive_en ? wdata_r : 16'hzzzz;
    assign dbg_state  = state;
    assign dbg_drive  = drive_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            grant_b      <= 1'b0;
            last_b       <= 1'b1;
            we_r         <= 1'b0;
            drive_en     <= 1'b0;
            wdata_r      <= 16'h0000;
            memAddrBus   <= 18'h00000;
            memRead      <= 1'b1;
            memWrite     <= 1'b1;
            memEnable    <= 1'b1;
            ports.aRdata <= 16'h0000;
            ports.bRdata <= 16'h0000;
            ports.aReady <= 1'b0;
            ports.bReady <= 1'b0;
        end else begin
            ports.aReady <= 1'b0;
            ports.bReady <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (grant_any) begin
                        state      <= SETUP;
                        grant_b    <= pick_b;
                        last_b     <= pick_b;
                        we_r       <= !pick_b && ports.aWe;
                        drive_en   <= !pick_b && ports.aWe;
                        wdata_r    <= ports.aWdata;
                        memAddrBus <= {ADDR_HI, (pick_b ? ports.bAddr : ports.aAddr)};
                        memEnable  <= 1'b0;
                        memRead    <= 1'b1;
                        memWrite   <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        memEnable <= 1'b1;
                        drive_en  <= 1'b0;
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                    cnt   <= 4'(ACCESS_CYCLES - 1);
                    if (we_r) memWrite <= 1'b0;
                    else      memRead  <= 1'b0;
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        // Strobes rise here; data (if writing) and address stay for hold.
                        state    <= DONE;
                        memRead  <= 1'b1;
                        memWrite <= 1'b1;
                        if (grant_b) begin
                            ports.bReady <= 1'b1;
                            ports.bRdata <= memDataBus;
                        end else begin
                            ports.aReady <= 1'b1;
                            if (!we_r) ports.aRdata <= memDataBus;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
